// File: rtl/eq_pkg.sv
// Shared equalizer constants: sample widths, I2S frame geometry and the
// 24-bit saturation limits used by the output stage.
package eq_pkg;

  localparam int SAMPLE_W   = 32;
  localparam int DAC_W      = 24;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  localparam logic [DAC_W-1:0] SAT_MAX = {1'b0, {(DAC_W-1){1'b1}}};
  localparam logic [DAC_W-1:0] SAT_MIN = {1'b1, {(DAC_W-1){1'b0}}};

endpackage

// File: rtl/eq_sat.sv
// Combinational signed clamp from IN_W to OUT_W bits with a clip flag.
// A value fits when every bit from the input MSB down to the output sign
// bit agrees; otherwise it is pinned to the rail matching its sign.
module eq_sat import eq_pkg::*; #(
  parameter int IN_W  = SAMPLE_W,
  parameter int OUT_W = DAC_W
) (
  input  logic [IN_W-1:0]  d_in,
  output logic [OUT_W-1:0] d_out,
  output logic             clip
);

  logic [IN_W-OUT_W:0] hi;
  logic                fits;

  assign hi   = d_in[IN_W-1:OUT_W-1];
  assign fits = (&hi) | ~(|hi);
  assign clip = ~fits;

  // Pass through when in range, else the positive or negative full scale
  always_comb begin
    d_out = d_in[OUT_W-1:0];
    if (!fits)
      d_out = d_in[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

endmodule

// File: rtl/eq_i2s_tx.sv
// Equalizer output stage: saturates the summed sample to OUT_W bits, holds
// one sample, and sends it on both I2S channels of a 64-bit frame. bclk and
// lrclk are derived from clk; clip/underrun are single-cycle status pulses.
module eq_i2s_tx import eq_pkg::*; #(
  parameter int CLK_DIV = 4,
  parameter int IN_W    = SAMPLE_W,
  parameter int OUT_W   = DAC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] d_in,
  input  logic            d_valid,
  output logic            d_ready,
  output logic            bclk,
  output logic            lrclk,
  output logic            sdata,
  output logic            clip,
  output logic            underrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam int P_W   = $clog2(SLOT_BITS);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic [P_W-1:0]       p_nxt;
  logic                 div_wrap, fall, wrap;
  logic                 hold_full, accept, sat_clip;
  logic [OUT_W-1:0]     hold, sat_val, frame_reg;
  logic [SLOT_BITS-1:0] slot;

  eq_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat (
    .d_in  (d_in),
    .d_out (sat_val),
    .clip  (sat_clip)
  );

  assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall     = div_wrap && bclk;
  assign bit_nxt  = bit_cnt + BIT_W'(1);
  assign wrap     = fall && (bit_cnt == '1);
  assign p_nxt    = bit_nxt[P_W-1:0];

  // Slot image MSB-first: bit 31 is the I2S delay bit (always 0), the sample
  // follows, and the tail is zero padding; slot position p reads slot[31-p].
  assign slot = {{(SLOT_BITS-OUT_W){1'b0}}, frame_reg} << (SLOT_BITS - 1 - OUT_W);

  assign d_ready = !hold_full;
  assign accept  = d_valid && d_ready;

  // Bit clock divider and frame position; lrclk/sdata move on bclk falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) bclk <= ~bclk;
      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= bit_nxt[BIT_W-1];
        sdata   <= slot[P_W'(SLOT_BITS - 1) - p_nxt];
      end
    end
  end

  // Holding register and frame load; a load in the accept cycle sees the
  // pre-accept (empty) hold, so the new sample waits for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold      <= '0;
      frame_reg <= '0;
      underrun  <= 1'b0;
      clip      <= 1'b0;
    end else begin
      underrun <= wrap && !hold_full;
      clip     <= accept && sat_clip;
      if (wrap) frame_reg <= hold_full ? hold : '0;
      if (accept) begin
        hold_full <= 1'b1;
        hold      <= sat_val;
      end else if (wrap) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule
